// File: rtl/timebase_scan_gen.sv
// Programmable-period tick generator (periodic / one-shot, pause, sync clear) plus free-running display scan.
// Optional blink square wave on tick, enabled by defining TIMEBASE_BLINK_EN.
module timebase_scan_gen #(
   parameter int unsigned CNT_W          = 27,
   parameter int unsigned PERIOD_DEFAULT = 50_000_000,
   parameter int unsigned SCAN_DIV       = 512,
   parameter int unsigned NDIG           = 4,
   parameter int unsigned SEL_W          = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             mode_i,
   input  logic             ld_i,
   input  logic [CNT_W-1:0] period_in_i,
   output logic             tick_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [7:0]       tick_cnt_o,
   output logic [SEL_W-1:0] sel_o,
   output logic             blink_o
);

   localparam int unsigned PSC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   period_q;
   logic               tick_q;
   logic [7:0]         tick_cnt_q;
   logic [PSC_W-1:0]   psc_q;
   logic [SEL_W-1:0]   sel_q;
   logic               wrap_c;
   logic               tick_d;
   logic [CNT_W-1:0]   period_d;

   // A wrap in RUN always produces a tick unless clr overrides it, even alongside ld.
   assign wrap_c   = (state_q == S_RUN) && (count_q == period_q - CNT_W'(1));
   assign tick_d   = wrap_c && !clr_i;
   assign period_d = (period_in_i == '0) ? CNT_W'(1) : period_in_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         period_q   <= CNT_W'(PERIOD_DEFAULT);
         tick_q     <= 1'b0;
         tick_cnt_q <= '0;
      end else begin
         tick_q <= tick_d;
         if (tick_d) tick_cnt_q <= tick_cnt_q + 8'd1;
         if (clr_i) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            tick_cnt_q <= '0;
         end else if (ld_i) begin
            period_q <= period_d;
            count_q  <= '0;
            if (state_q == S_DONE) state_q <= en_i ? S_RUN : S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  count_q <= '0;
                  if (en_i) state_q <= S_RUN;
               end
               S_RUN: begin
                  if (wrap_c) begin
                     count_q <= '0;
                     if (mode_i)     state_q <= S_DONE;
                     else if (!en_i) state_q <= S_PAUSE;
                  end else if (!en_i) begin
                     state_q <= S_PAUSE;
                  end else begin
                     count_q <= count_q + CNT_W'(1);
                  end
               end
               S_PAUSE: if (en_i) state_q <= S_RUN;
               S_DONE:  count_q <= '0;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   // Scan prescaler and digit select run from reset regardless of the tick path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         psc_q <= '0;
         sel_q <= '0;
      end else if (psc_q == PSC_W'(SCAN_DIV - 1)) begin
         psc_q <= '0;
         sel_q <= (sel_q == SEL_W'(NDIG - 1)) ? '0 : sel_q + SEL_W'(1);
      end else begin
         psc_q <= psc_q + PSC_W'(1);
      end
   end

`ifdef TIMEBASE_BLINK_EN
   logic blink_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         blink_q <= 1'b0;
      else if (clr_i)  blink_q <= 1'b0;
      else if (tick_d) blink_q <= ~blink_q;
   end
   assign blink_o = blink_q;
`else
   assign blink_o = 1'b0;
`endif

   assign tick_o     = tick_q;
   assign tick_cnt_o = tick_cnt_q;
   assign sel_o      = sel_q;
   assign busy_o     = (state_q == S_RUN) || (state_q == S_PAUSE);
   assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_timebase_scan_gen.sv
// Self-checking bench for timebase_scan_gen: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_timebase_scan_gen;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned PDEF  = 10;
   localparam int unsigned SDIV  = 4;
   localparam int unsigned NDIG  = 3;
   localparam int unsigned SEL_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0, clr = 1'b0, mode = 1'b0, ld = 1'b0;
   logic [CNT_W-1:0] pin = '0;
   logic             tick, busy, done, blink;
   logic [7:0]       tick_cnt;
   logic [SEL_W-1:0] sel;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: phase = cycles elapsed in the current period
   int m_st;   // 0 idle, 1 run, 2 pause, 3 done
   int m_phase, m_per, m_tcnt, scan_cyc;
   bit m_tick, m_blink;

   timebase_scan_gen #(
      .CNT_W(CNT_W), .PERIOD_DEFAULT(PDEF), .SCAN_DIV(SDIV), .NDIG(NDIG), .SEL_W(SEL_W)
   ) dut (
      .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .mode_i(mode), .ld_i(ld),
      .period_in_i(pin), .tick_o(tick), .busy_o(busy), .done_o(done),
      .tick_cnt_o(tick_cnt), .sel_o(sel), .blink_o(blink)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] exp_vec();
      bit b;
`ifdef TIMEBASE_BLINK_EN
      b = m_blink;
`else
      b = 1'b0;
`endif
      return {m_tick, (m_st == 1 || m_st == 2), (m_st == 3), 8'(m_tcnt), b};
   endfunction

   function automatic logic [11:0] dut_vec();
      return {tick, busy, done, tick_cnt, blink};
   endfunction

   function automatic int exp_sel();
      return (scan_cyc / SDIV) % NDIG;
   endfunction

   task automatic model_reset();
      m_st = 0; m_phase = 0; m_per = PDEF; m_tcnt = 0; m_tick = 0; m_blink = 0; scan_cyc = 0;
   endtask

   // One clock edge of the specified behaviour
   task automatic model_edge();
      bit period_end;
      period_end = (m_st == 1) && (m_phase + 1 == m_per);
      m_tick = period_end && !clr;
      if (m_tick) begin
         m_tcnt = (m_tcnt + 1) % 256;
         m_blink = !m_blink;
      end
      if (clr) begin
         m_st = 0; m_phase = 0; m_tcnt = 0; m_blink = 0;
      end else if (ld) begin
         m_per = (pin == 0) ? 1 : int'(pin);
         m_phase = 0;
         if (m_st == 3) m_st = en ? 1 : 0;
      end else if (m_st == 0) begin
         if (en) m_st = 1;
      end else if (m_st == 1) begin
         if (period_end) begin
            m_phase = 0;
            m_st = mode ? 3 : (en ? 1 : 2);
         end else if (!en) m_st = 2;
         else m_phase++;
      end else if (m_st == 2) begin
         if (en) m_st = 1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      scan_cyc++;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 0; clr = 0; mode = 0; ld = 0; pin = '0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (dut_vec() !== 12'h000) begin
         n_bad++; $display("FAIL reset_outputs got %h want %h", dut_vec(), 12'h000);
      end
      n_cmp++;
      if (sel !== '0) begin
         n_bad++; $display("FAIL reset_sel got %0d want 0", sel);
      end
   endtask

   task automatic test_periodic();
      en = 1; mode = 0;
      for (int i = 1; i <= 35; i++) begin
         step();
         n_cmp++;
         if (tick !== (i == 11 || i == 21 || i == 31)) begin
            n_bad++; $display("FAIL periodic_tick step %0d got %b want %b", i, tick, (i == 11 || i == 21 || i == 31));
         end
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL periodic_model step %0d got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      n_cmp++;
      if (tick_cnt !== 8'd3) begin
         n_bad++; $display("FAIL periodic_count got %0d want 3", tick_cnt);
      end
   endtask

   task automatic test_oneshot();
      clr = 1; step(); clr = 0;
      en = 0; ld = 1; pin = 5; step(); ld = 0;
      en = 1; mode = 1;
      for (int i = 1; i <= 60; i++) begin
         step();
         n_cmp++;
         if (tick !== (i == 6)) begin
            n_bad++; $display("FAIL oneshot_tick step %0d got %b want %b", i, tick, (i == 6));
         end
         n_cmp++;
         if (i >= 6 && {done, busy} !== 2'b10) begin
            n_bad++; $display("FAIL oneshot_done step %0d got done=%b busy=%b want done=1 busy=0", i, done, busy);
         end
      end
      en = 0; clr = 1; step(); clr = 0; mode = 0;
      n_cmp++;
      if ({done, busy, tick_cnt} !== 10'd0) begin
         n_bad++; $display("FAIL oneshot_clr got done=%b busy=%b cnt=%0d want 0/0/0", done, busy, tick_cnt);
      end
   endtask

   task automatic test_pause();
      logic [7:0] held;
      clr = 1; step(); clr = 0;
      ld = 1; pin = 10; step(); ld = 0;
      en = 1; mode = 0; step();
      repeat (4) step();
      held = tick_cnt;
      en = 0;
      for (int i = 1; i <= 7; i++) begin
         step();
         n_cmp++;
         if ({tick, busy, tick_cnt} !== {1'b0, 1'b1, held}) begin
            n_bad++; $display("FAIL pause_hold step %0d got tick=%b busy=%b cnt=%0d want 0/1/%0d", i, tick, busy, tick_cnt, held);
         end
      end
      en = 1; step();
      for (int j = 1; j <= 6; j++) begin
         step();
         n_cmp++;
         if (tick !== (j == 6)) begin
            n_bad++; $display("FAIL pause_resume step %0d got %b want %b", j, tick, (j == 6));
         end
      end
   endtask

   task automatic test_load();
      clr = 1; step(); clr = 0;
      ld = 1; pin = 10; step(); ld = 0;
      en = 1; mode = 0; step();
      repeat (7) step();
      ld = 1; pin = 3; step(); ld = 0;
      for (int j = 1; j <= 9; j++) begin
         step();
         n_cmp++;
         if (tick !== (j % 3 == 0)) begin
            n_bad++; $display("FAIL load_new_period step %0d got %b want %b", j, tick, (j % 3 == 0));
         end
      end
      ld = 1; pin = 0; step(); ld = 0;
      for (int j = 1; j <= 8; j++) begin
         step();
         n_cmp++;
         if (tick !== 1'b1) begin
            n_bad++; $display("FAIL load_zero step %0d got %b want 1", j, tick);
         end
      end
      clr = 1; ld = 1; pin = 7; step(); clr = 0; ld = 0;
      step();
      step();
      n_cmp++;
      if (tick !== 1'b1) begin
         n_bad++; $display("FAIL clr_ld_period got %b want 1", tick);
      end
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
         n_bad++; $display("FAIL load_model got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_scan();
      do_reset();
      for (int i = 0; i < 150; i++) begin
         en = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 15) == 0);
         mode = (i > 60);
         ld = ($urandom_range(0, 19) == 0);
         pin = CNT_W'($urandom_range(0, 5));
         step();
         n_cmp++;
         if (int'(sel) !== exp_sel()) begin
            n_bad++; $display("FAIL scan_sel cycle %0d got %0d want %0d", scan_cyc, sel, exp_sel());
         end
      end
      clr = 0; ld = 0;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         en = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 39) == 0);
         ld = ($urandom_range(0, 19) == 0);
         pin = CNT_W'($urandom_range(0, 6));
         if ($urandom_range(0, 49) == 0) mode = ~mode;
         step();
         n_cmp++;
         if (dut_vec() !== exp_vec() || int'(sel) !== exp_sel()) begin
            n_bad++; $display("FAIL random step %0d got %h sel %0d want %h sel %0d", i, dut_vec(), sel, exp_vec(), exp_sel());
         end
      end
      clr = 0; ld = 0; mode = 0;
   endtask

   task automatic test_async_reset();
      clr = 1; step(); clr = 0;
      ld = 1; pin = 4; step(); ld = 0;
      en = 1; mode = 0;
      repeat (6) step();
      #2 rst = 1'b1;
      #1;
      model_reset();
      n_cmp++;
      if (dut_vec() !== 12'h000 || sel !== '0) begin
         n_bad++; $display("FAIL async_reset got %h sel %0d want 000 sel 0", dut_vec(), sel);
      end
      #1 rst = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         step();
         n_cmp++;
         if (tick !== (i == 11)) begin
            n_bad++; $display("FAIL reset_default_period step %0d got %b want %b", i, tick, (i == 11));
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_periodic();
      test_oneshot();
      test_pause();
      test_load();
      test_scan();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/timebase_scan_gen.md
Name: timebase_scan_gen

Overview:
- Parametrised timebase generator with two outputs: a programmable-period tick pulse, and an independent display-scan digit selector.
- Generalises the fixed single-constant tick/select counter: runtime period load, periodic or one-shot mode, pause/resume, sync clear, tick counter, N-digit scan.
- Feeds game-speed logic (tick) and the multiplexed 7-segment display driver (sel).

Parameters:
- CNT_W, 27, width of period register and main counter.
- PERIOD_DEFAULT, 50_000_000, reset value of period register (1 s at 50 MHz).
- SCAN_DIV, 512, clk cycles per scan digit.
- NDIG, 4, number of display digits; sel counts 0..NDIG-1.
- SEL_W, 2, width of sel; must satisfy 2^SEL_W >= NDIG.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  run enable (level)
- clr  in  1  synchronous clear
- mode  in  1  0 = periodic, 1 = one-shot
- ld  in  1  load period_in (1-cycle strobe)
- period_in  in  CNT_W  new period in clk cycles
- tick  out  1  one-cycle pulse, registered
- busy  out  1  high in RUN or PAUSE
- done  out  1  high in DONE
- tick_cnt  out  8  count of ticks since rst/clr, wraps 255->0
- sel  out  SEL_W  scan digit index, registered
- blink  out  1  see Optional Feature

Behaviour:
- Reset (rst=1, async) values:
  - state=IDLE, count=0, period_reg=PERIOD_DEFAULT.
  - tick=0, busy=0, done=0, tick_cnt=0, sel=0, blink=0, scan prescaler=0.
- Period rules:
  - Load value period_in=0 is stored as 1. Stored period_reg=1 gives tick high every cycle while RUN.
  - count runs 0..period_reg-1.
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE: count=0. en=1 -> RUN.
  - RUN: count increments each cycle.
    - Wrap: when count==period_reg-1, tick=1 next cycle, tick_cnt+1, count->0.
    - Periodic: stay RUN. One-shot: -> DONE.
    - en=0 (and no wrap that cycle) -> PAUSE, count held.
  - PAUSE: count and tick_cnt held, tick=0. en=1 -> RUN, resuming from the held count.
  - DONE: done=1, count=0. Leaves only via clr (-> IDLE) or ld (-> RUN if en=1, else IDLE).
- Tick timing:
  - First tick is high in the cycle P clocks after the edge that enters RUN, where P=period_reg.
  - Periodic ticks then repeat every P clocks, each exactly 1 cycle wide.
  - mode is sampled at each wrap.
- Priority: rst > clr > ld > en/count.
- clr: state=IDLE, count=0, tick_cnt=0, tick=0, blink=0. period_reg is retained.
- ld:
  - Updates period_reg the next cycle and resets count to 0.
  - In RUN it stays in RUN; the next tick comes P_new clocks later.
  - In IDLE/PAUSE the state is unchanged.
  - ld coincident with a wrap: the tick for that wrap is still issued, then counting restarts from the new period.
  - clr together with ld: ld is ignored.
- Scan path:
  - Free-running from reset; unaffected by en, clr, ld or state.
  - Prescaler counts 0..SCAN_DIV-1. At wrap, sel increments, going NDIG-1 -> 0.
  - sel holds each value for exactly SCAN_DIV cycles.
- busy and done are decoded from registered state, with no combinational path from inputs.

Optional Feature:
- Macro: TIMEBASE_BLINK_EN.
- Defined: blink toggles on every tick, giving a 50% square wave of period 2P. It is held in PAUSE/DONE, cleared by clr and rst.
- Undefined: blink is tied to 0 and the toggle flop is not instantiated.

Test Plan:
- PERIOD_DEFAULT=10, mode=0, en=1 from cycle 0 -> tick at cycles 10, 20, 30; each pulse 1 cycle wide; tick_cnt=3 after cycle 30.
- mode=1, period 5, en=1 -> single tick at cycle 5, done=1, busy=0. No further ticks for 50 cycles. clr -> done=0, state IDLE.
- Periodic, period 10:
  - en dropped at count=4 for 7 cycles, then raised -> next tick 6 cycles after resume.
  - tick_cnt and count held throughout the pause.
- ld period_in=3 while RUN at count=7 (old period 10) -> ticks 3, 6, 9 cycles after ld.
  - period_in=0 -> tick high continuously.
  - clr and ld in the same cycle -> period unchanged.
- SCAN_DIV=4, NDIG=3 -> sel sequence 0,1,2,0 changing every 4 cycles. Unaffected by en=0, clr pulses and one-shot DONE.
- rst asserted mid-RUN, asynchronously between edges -> all outputs return to reset values immediately and period_reg=PERIOD_DEFAULT. With TIMEBASE_BLINK_EN, blink toggles 0->1->0 on consecutive ticks.
